// File: rtl/pio_rx_uart.sv
// Drains one PIO RX FIFO and transmits each 32-bit word on tx as 8N1 UART, 4 raw bytes LSB-first.
// Define PIO_RX_UART_HEX_EN to send 8 uppercase hex digits plus CR LF per word instead.
module pio_rx_uart #(
  parameter int         CLK_DIV   = 217,
  parameter int         MINDEX    = 0,
  parameter logic [3:0] ACTION_RD = 4'd6
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  rx_empty,
  input  logic [31:0] dout,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic        tx,
  output logic        busy
);

`ifdef PIO_RX_UART_HEX_EN
  localparam int NCHARS = 10;
`else
  localparam int NCHARS = 4;
`endif
  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, READ, WAIT, CAPTURE, SEND} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [3:0]        char_cnt;
  logic [31:0]       word;
  logic [8:0]        shreg;
  logic              tx_q;
  logic              sel_empty;
  logic              baud_wrap;
  logic              frame_end;
  logic              word_end;

  function automatic logic [7:0] char_of(input logic [31:0] w, input logic [3:0] idx);
`ifdef PIO_RX_UART_HEX_EN
    logic [3:0] nib;
    nib = w[5'd28 - {idx[2:0], 2'b00} +: 4];
    if (idx == 4'd8)
      return 8'h0D;
    if (idx == 4'd9)
      return 8'h0A;
    return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
`else
    return 8'(w >> {idx, 3'b000});
`endif
  endfunction

  assign sel_empty = |(rx_empty & (4'b0001 << MINDEX));
  assign baud_wrap = (baud_cnt == BAUD_W'(CLK_DIV - 1));
  assign frame_end = baud_wrap && (bit_cnt == 4'd9);
  assign word_end  = frame_end && (char_cnt == 4'(NCHARS - 1));

  assign mindex = 2'(MINDEX);
  assign busy   = (state != IDLE);
  assign tx     = tx_q;

  always_ff @(posedge clk_25mhz) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // READ is the strobe cycle; the PIO returns data one cycle later, captured in CAPTURE.
  always_comb begin
    state_nxt = state;
    action    = 4'd0;
    case (state)
      IDLE:    if (enable && !sel_empty) state_nxt = READ;
      READ: begin
        action    = ACTION_RD;
        state_nxt = WAIT;
      end
      WAIT:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (word_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered: the start bit is driven from the CAPTURE edge so it appears with SEND.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_cnt <= '0;
      word     <= '0;
      shreg    <= '1;
      tx_q     <= 1'b1;
    end else if (state == CAPTURE) begin
      word     <= dout;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      char_cnt <= '0;
      shreg    <= {1'b1, char_of(dout, 4'd0)};
      tx_q     <= 1'b0;
    end else if (state == SEND) begin
      if (!baud_wrap) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        if (bit_cnt != 4'd9) begin
          bit_cnt <= bit_cnt + 4'd1;
          tx_q    <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end else if (word_end) begin
          bit_cnt  <= '0;
          char_cnt <= '0;
          tx_q     <= 1'b1;
        end else begin
          bit_cnt  <= '0;
          char_cnt <= char_cnt + 4'd1;
          shreg    <= {1'b1, char_of(word, char_cnt + 4'd1)};
          tx_q     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/pio_rx_uart.md
# pio_rx_uart

Drains 32-bit words from one PIO state machine's RX FIFO and sends them out on the board's serial `tx` pin as 8N1 UART. It sits next to the PIO instance in the top level, on the read side of the PIO host port, and complements the program/configuration loader that drives that port during start-up. The top level hands the host port (`action`, `mindex`) to this block once loading is complete.

## Interface
Parameters:
- `CLK_DIV`, 217: clock cycles per UART bit (25 MHz / 115200 baud).
- `MINDEX`, 0: index of the PIO state machine whose RX FIFO is drained.
- `ACTION_RD`, 4'd6: PIO action code that pops one word from the RX FIFO.

Ports:
- `clk_25mhz` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: high once the loader has finished; permits new reads.
- `rx_empty` in 4: per-machine RX-empty flags from the PIO.
- `dout` in 32: PIO read data, valid in the cycle after an `ACTION_RD` strobe.
- `action` out 4: PIO action. Equals `ACTION_RD` for one cycle per read, otherwise 0.
- `mindex` out 2: PIO machine index, constant `MINDEX`.
- `tx` out 1: UART line. Idle level is high.
- `busy` out 1: high from the read strobe until the last stop bit ends.

## Operation
State machine:
- **IDLE**
  - Condition: `enable && !rx_empty[MINDEX]`.
  - Action: drive `action=ACTION_RD` for exactly one cycle, set `busy`, go to WAIT.
- **WAIT** (1 cycle)
  - `action=0`.
  - Go to CAPTURE.
- **CAPTURE** (1 cycle)
  - Register `dout` into a 32-bit word register.
  - Load the first character, go to SEND.
- **SEND**
  - Shift out a 10-bit frame: start bit (0), 8 data bits LSB-first, stop bit (1).
  - Next character starts in the cycle after the stop bit ends; no idle gap.
  - After the last character's stop bit: clear `busy`, go to IDLE.

Character order (raw mode): bytes `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.

Boundary conditions:
- `enable` falls mid-word: the current word completes. No new strobe is issued while `enable` is low.
- FIFO refills during SEND: ignored until IDLE. There is no lookahead read, and a full PIO FIFO simply stalls the PIO.
- `rx_empty` rises in the same cycle as the strobe: the strobe is still issued once. The PIO defines the returned data; this block transmits whatever `dout` holds.
- Reset mid-frame: `tx` returns high and the state machine returns to IDLE on the next edge. A partially sent character is abandoned.

## Timing
Reset values:
- `action=0`
- `mindex=MINDEX`
- `tx=1`
- `busy=0`
- bit counter, character counter and baud counter all 0

Cycle-level timing:
- Strobe at cycle T. `dout` is sampled at T+2. The start bit begins at T+3.
- Each bit holds for exactly `CLK_DIV` cycles. The baud counter counts 0..CLK_DIV-1 and advances the bit on wrap.
- Raw word duration: 40×`CLK_DIV` = 8680 cycles with the default.
- Minimum strobe-to-strobe spacing: 3 + 40×`CLK_DIV` + 1 cycles (one IDLE cycle between words).

## Configuration
- `PIO_RX_UART_HEX_EN` defined: each word is sent as 10 characters.
  - 8 uppercase ASCII hex digits, most-significant nibble first.
  - Followed by CR (0x0D) and LF (0x0A).
  - Word duration: 100×`CLK_DIV` cycles.
- Not defined: raw mode, 4 binary bytes per word as above; hex encoding logic is not built.

## Test plan
- **Reset state:** hold `reset` 5 cycles with `rx_empty=4'hF` → `tx=1`, `action=0`, `busy=0` throughout and afterwards.
- **Single word, raw:** `enable=1`, `rx_empty[0]` low for one strobe, `dout=32'h12345678` at T+2 →
  - exactly one `action=6` pulse;
  - `tx` carries bytes 0x78, 0x56, 0x34, 0x12;
  - each bit is 217 cycles wide;
  - `busy` falls 8680+3 cycles after the strobe.
- **Back-to-back:** FIFO presents two words 0xA5A5A5A5 and 0x0000FFFF → two strobes, 8684 cycles apart, both words serialised correctly.
- **Enable gating:** `rx_empty[0]=0` with `enable=0` for 1000 cycles → no strobe and `tx` stays high. Raise `enable` → strobe on the next cycle.
- **Reset mid-frame:** assert `reset` during the third bit of byte 1 → `tx=1` and `busy=0` on the next edge. The next word after release is sent complete from its start bit.
- **Hex mode** (`PIO_RX_UART_HEX_EN`): `dout=32'hDEADBEEF` → characters "DEADBEEF", 0x0D, 0x0A; `busy` high for 21700+3 cycles.
